// File: rtl/csr_ctrl_pkg.sv
// Shared definitions for the CSR instruction-queue controller.
//   CSR_OPW      default CSR op / queue entry width
//   CSR_Q_DEPTH  number of entries in the CSR instruction queue
//   issue_state_e  issue FSM encoding
package csr_ctrl_pkg;

  localparam int unsigned CSR_OPW     = 23;
  localparam int unsigned CSR_Q_DEPTH = 8;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StRead     = 2'd1,
    StPresent  = 2'd2,
    StWaitDone = 2'd3
  } issue_state_e;

endpackage

// File: rtl/csr_push_arb.sv
// Merges the two decode lanes onto the queue's single write port.
// When both lanes arrive together, lane0 is written and lane1 is parked in a one-entry
// pending register that gets first claim on the write port next cycle.
// Ports:
//   Clk, Rest            clock, synchronous active-high reset
//   Dec0Valid/Dec0Op     older decode lane
//   Dec1Valid/Dec1Op     younger decode lane
//   QFull                queue full
//   Flush                pipeline redirect; drops the pending op and blocks the write
//   DecStall             decode must hold both lanes
//   QWable/QDin          queue write enable / data
module csr_push_arb
  import csr_ctrl_pkg::*;
#(
  parameter int unsigned OPW = CSR_OPW
) (
  input  logic           Clk,
  input  logic           Rest,
  input  logic           Dec0Valid,
  input  logic [OPW-1:0] Dec0Op,
  input  logic           Dec1Valid,
  input  logic [OPW-1:0] Dec1Op,
  input  logic           QFull,
  input  logic           Flush,
  output logic           DecStall,
  output logic           QWable,
  output logic [OPW-1:0] QDin
);

  logic           pend_valid_q, pend_valid_d;
  logic [OPW-1:0] pend_q, pend_d;
  logic           src_valid;
  logic [OPW-1:0] src_op;
  logic           dec_stall;
  logic           wr_en;

  always_comb begin
    src_valid    = 1'b0;
    src_op       = '0;
    pend_valid_d = pend_valid_q;
    pend_d       = pend_q;

    // The parked lane1 op is always older than anything currently on the lanes.
    if (pend_valid_q) begin
      src_valid = 1'b1;
      src_op    = pend_q;
    end else if (Dec0Valid) begin
      src_valid = 1'b1;
      src_op    = Dec0Op;
    end else if (Dec1Valid) begin
      src_valid = 1'b1;
      src_op    = Dec1Op;
    end

    dec_stall = QFull | pend_valid_q;
    wr_en     = src_valid & ~QFull & ~Flush;

    if (Flush) begin
      pend_valid_d = 1'b0;
    end else if (pend_valid_q && wr_en) begin
      pend_valid_d = 1'b0;
    end else if (!dec_stall && Dec0Valid && Dec1Valid) begin
      // lane0 takes the write port this cycle; lane1 is consumed into the pending slot
      pend_valid_d = 1'b1;
      pend_d       = Dec1Op;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rest) begin
      pend_valid_q <= 1'b0;
      pend_q       <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_q       <= pend_d;
    end
  end

  // Handshake outputs are forced low while reset is asserted.
  assign DecStall = dec_stall & ~Rest;
  assign QWable   = wr_en & ~Rest;
  assign QDin     = src_op;

endmodule

// File: rtl/csr_issue_ctrl.sv
// Controller for the 8-entry CSR instruction queue. Merges the decode lanes into the
// queue (via csr_push_arb), reads the queue and issues one CSR op at a time, strictly
// serialized on CsrDone. Flush clears the queue and aborts any not-yet-acked op; an
// acked op always runs to completion. A watchdog flags ops stuck in WAIT_DONE.
// Ports:
//   Clk, Rest                     clock, synchronous active-high reset
//   Dec0Valid/Dec0Op, Dec1Valid/Dec1Op  decode lanes (lane0 older)
//   DecStall                      decode hold
//   QWable/QDin, QFull, QEmpty    queue write side and status
//   QRable, QDout                 queue read enable, registered read data (next cycle)
//   QClean                        queue pointer clear
//   Flush                         pipeline redirect / exception
//   IssueValid/IssueOp/IssueAck   issue handshake to the CSR unit
//   CsrDone                       completion of the issued op
//   Busy                          op presented or outstanding
//   TimeoutErr                    sticky watchdog error
module csr_issue_ctrl
  import csr_ctrl_pkg::*;
#(
  parameter int unsigned OPW     = CSR_OPW,
  parameter int unsigned TOW     = 8,
  parameter int unsigned TIMEOUT = 200
) (
  input  logic           Clk,
  input  logic           Rest,
  input  logic           Dec0Valid,
  input  logic [OPW-1:0] Dec0Op,
  input  logic           Dec1Valid,
  input  logic [OPW-1:0] Dec1Op,
  output logic           DecStall,
  output logic           QWable,
  output logic [OPW-1:0] QDin,
  input  logic           QFull,
  input  logic           QEmpty,
  output logic           QRable,
  input  logic [OPW-1:0] QDout,
  output logic           QClean,
  input  logic           Flush,
  output logic           IssueValid,
  output logic [OPW-1:0] IssueOp,
  input  logic           IssueAck,
  input  logic           CsrDone,
  output logic           Busy,
  output logic           TimeoutErr
);

  localparam logic [TOW-1:0] TimeoutCnt = TOW'(TIMEOUT);

  issue_state_e   state_q, state_d;
  logic [OPW-1:0] issue_op_q, issue_op_d;
  logic [TOW-1:0] wdog_q, wdog_d;
  logic           timeout_q, timeout_d;
  logic           q_rd;
  logic           issue_valid;

  csr_push_arb #(
    .OPW(OPW)
  ) u_push_arb (
    .Clk      (Clk),
    .Rest     (Rest),
    .Dec0Valid(Dec0Valid),
    .Dec0Op   (Dec0Op),
    .Dec1Valid(Dec1Valid),
    .Dec1Op   (Dec1Op),
    .QFull    (QFull),
    .Flush    (Flush),
    .DecStall (DecStall),
    .QWable   (QWable),
    .QDin     (QDin)
  );

  always_comb begin
    state_d     = state_q;
    issue_op_d  = issue_op_q;
    wdog_d      = wdog_q;
    timeout_d   = timeout_q;
    q_rd        = 1'b0;
    issue_valid = 1'b0;

    case (state_q)
      StIdle: begin
        if (!QEmpty && !Flush) begin
          q_rd    = 1'b1;
          state_d = StRead;
        end
      end
      StRead: begin
        if (Flush) begin
          state_d = StIdle;
        end else begin
          issue_op_d = QDout;
          state_d    = StPresent;
        end
      end
      StPresent: begin
        // A flushed op is speculative: withdraw it and ignore a same-cycle ack.
        issue_valid = ~Flush;
        if (Flush) begin
          state_d = StIdle;
        end else if (IssueAck) begin
          state_d = StWaitDone;
          wdog_d  = '0;
        end
      end
      StWaitDone: begin
        // Acked op is committed, so Flush does not affect this state.
        if (wdog_q != '1) begin
          wdog_d = wdog_q + 1'b1;
        end
        if (wdog_d >= TimeoutCnt) begin
          timeout_d = 1'b1;
        end
        if (CsrDone) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rest) begin
      state_q    <= StIdle;
      issue_op_q <= '0;
      wdog_q     <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      issue_op_q <= issue_op_d;
      wdog_q     <= wdog_d;
      timeout_q  <= timeout_d;
    end
  end

  assign QRable     = q_rd & ~Rest;
  assign QClean     = Flush & ~Rest;
  assign IssueValid = issue_valid & ~Rest;
  assign IssueOp    = Rest ? '0 : issue_op_q;
  assign Busy       = ~Rest & ((state_q == StPresent) || (state_q == StWaitDone));
  assign TimeoutErr = timeout_q;

endmodule
